seven_seg_scan: RTL

Multiplexed four-digit seven-segment display driver and the consumer of the stopwatch counter's BCD digit outputs (num3 num2 : num1 num0, MM:SS). It runs on the fast board clock and scans one digit at a time. Each digit is decoded BCD to active-low segments, with an optional colon and optional leading-zero blanking. Digit values are snapshotted once per frame so a count change never tears across digits mid-frame.

---
 rtl/seven_seg_scan.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame digit snapshot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic       colon,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       snap0, snap1, snap2, snap3;
  logic             snap_colon;

  logic             cnt_wrap;
  logic             frame_wrap;
  logic             window;
  logic [3:0]       cur_digit;
  logic             lz_blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign frame_wrap = cnt_wrap && (idx == 2'd3);

  // Prescaler, scan index and frame snapshot
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap0      <= '0;
      snap1      <= '0;
      snap2      <= '0;
      snap3      <= '0;
      snap_colon <= 1'b0;
    end else begin
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_wrap) begin
        snap0      <= num0;
        snap1      <= num1;
        snap2      <= num2;
        snap3      <= num3;
        snap_colon <= colon;
      end
    end
  end

  always_comb begin
    cur_digit = snap0;
    case (idx)
      2'd0:    cur_digit = snap0;
      2'd1:    cur_digit = snap1;
      2'd2:    cur_digit = snap2;
      default: cur_digit = snap3;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A dash (>9) is nonzero, so it stops blanking of lower digits
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (snap3 == 4'd0);
      2'd2:    lz_blank = (snap3 == 4'd0) && (snap2 == 4'd0);
      2'd1:    lz_blank = (snap3 == 4'd0) && (snap2 == 4'd0) && (snap1 == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  always_comb begin
    window  = (cnt >= CNT_BLANK);
    an_nxt  = 4'b1111;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (window) begin
      an_nxt = ~(4'b0001 << idx);
    end
    if (!lz_blank) begin
      seg_nxt = bcd_to_seg(cur_digit);
    end
    if (window && (idx == 2'd2) && snap_colon) begin
      dp_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
